// File: rtl/conv_seq_pkg.sv
// Shared state codes and sizing helper for the conversion sequencer.
package conv_seq_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StChoose = 3'd1,
    StRun    = 3'd2,
    StDone   = 3'd3,
    StError  = 3'd4
  } conv_state_e;

  // Width of a stage pointer; never zero so a single-stage chain still has a port.
  function automatic int unsigned ptr_width(input int unsigned num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/next_stage_finder.sv
// Masked priority encoder: lowest enabled stage above ptr_i, or the lowest
// enabled stage overall when from_start_i is set.
module next_stage_finder
  import conv_seq_pkg::*;
#(
  parameter int unsigned NumStages = 4,
  parameter int unsigned PtrW      = ptr_width(NumStages)
) (
  input  logic [NumStages-1:0] mask_i,
  input  logic [PtrW-1:0]      ptr_i,
  input  logic                 from_start_i,
  output logic [PtrW-1:0]      nxt_idx_o,
  output logic                 nxt_valid_o
);

  always_comb begin
    nxt_idx_o   = '0;
    nxt_valid_o = 1'b0;
    // Scan downwards so the lowest qualifying bit is the last one written.
    for (int i = NumStages - 1; i >= 0; i--) begin
      if (mask_i[i] && (from_start_i || (i > int'(ptr_i)))) begin
        nxt_idx_o   = PtrW'(i);
        nxt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conversion_sequencer.sv
// Restartable per-element stage sequencer with run-time stage skipping.
// Optional per-stage watchdog enabled by defining CONV_SEQ_STAGE_TIMEOUT_EN.
module conversion_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TMO_W      = 16
) (
  input  logic                  clk,
  input  logic                  program_reset,
  input  logic                  start_process,
  input  logic [CNT_W-1:0]      num_elements,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic                  data_reset_done,
  input  logic                  element_chosen,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  go_reset_data,
  output logic                  go_choose_element,
  output logic [NUM_STAGES-1:0] stage_go,
  output logic [CNT_W-1:0]      elem_index,
  output logic                  end_process,
  output logic                  busy,
  output logic                  error,
  output logic [StateW-1:0]     current_state
);

  localparam int unsigned PtrW = ptr_width(NUM_STAGES);

  conv_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       nxt_idx;
  logic                  nxt_valid;

`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
  logic [TMO_W-1:0] wdog_q, wdog_d, wdog_inc;
  assign wdog_inc = wdog_q + TMO_W'(1);
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
`endif

  // Outside RUN the finder yields the first enabled stage; inside, nxt(ptr).
  next_stage_finder #(
    .NumStages (NUM_STAGES),
    .PtrW      (PtrW)
  ) u_finder (
    .mask_i       (mask_q),
    .ptr_i        (ptr_q),
    .from_start_i (state_q != StRun),
    .nxt_idx_o    (nxt_idx),
    .nxt_valid_o  (nxt_valid)
  );

  always_ff @(posedge clk) begin
    if (program_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (data_reset_done && start_process) begin
          cnt_d   = num_elements;
          mask_d  = stage_mask;
          idx_d   = '0;
          state_d = (num_elements == '0) ? StDone : StChoose;
        end
      end
      StChoose: begin
        if (idx_q == cnt_q) begin
          state_d = StDone;
        end else if (element_chosen) begin
          if (nxt_valid) begin
            ptr_d   = nxt_idx;
            state_d = StRun;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      StRun: begin
        if (stage_done[ptr_q]) begin
          if (nxt_valid) begin
            ptr_d  = nxt_idx;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
            wdog_d = '0;
`endif
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = StChoose;
          end
        end else begin
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
          wdog_d = wdog_inc;
          if (&wdog_inc) state_d = StError;
`endif
        end
      end
      StDone: begin
        if (!start_process) state_d = StIdle;
      end
      StError: begin
        state_d = StError;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    go_reset_data     = (state_q == StIdle);
    go_choose_element = (state_q == StChoose);
    stage_go          = (state_q == StRun) ? (NUM_STAGES'(1) << ptr_q) : '0;
    elem_index        = idx_q;
    end_process       = (state_q == StDone);
    busy              = (state_q == StChoose) || (state_q == StRun);
    current_state     = state_q;
`ifdef CONV_SEQ_STAGE_TIMEOUT_EN
    error             = (state_q == StError);
`else
    error             = 1'b0;
`endif
  end

endmodule

// File: tb/tb_conversion_sequencer.sv
// Directed plus randomized bench for conversion_sequencer (default build, no watchdog).
module tb_conversion_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          program_reset;
  logic          start_process;
  logic [CW-1:0] num_elements;
  logic [NS-1:0] stage_mask;
  logic          data_reset_done;
  logic          element_chosen;
  logic [NS-1:0] stage_done;
  logic          go_reset_data;
  logic          go_choose_element;
  logic [NS-1:0] stage_go;
  logic [CW-1:0] elem_index;
  logic          end_process;
  logic          busy;
  logic          error;
  logic [2:0]    current_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conversion_sequencer #(
    .NUM_STAGES (NS),
    .CNT_W      (CW),
    .TMO_W      (16)
  ) dut (
    .clk               (clk),
    .program_reset     (program_reset),
    .start_process     (start_process),
    .num_elements      (num_elements),
    .stage_mask        (stage_mask),
    .data_reset_done   (data_reset_done),
    .element_chosen    (element_chosen),
    .stage_done        (stage_done),
    .go_reset_data     (go_reset_data),
    .go_choose_element (go_choose_element),
    .stage_go          (stage_go),
    .elem_index        (elem_index),
    .end_process       (end_process),
    .busy              (busy),
    .error             (error),
    .current_state     (current_state)
  );

  localparam logic [31:0] SIdle = 0, SChoose = 1, SRun = 2, SDone = 3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: each element is one CHOOSE visit, then the enabled stages in ascending order.
  task automatic run_pass(input int n, input logic [NS-1:0] mask);
    int stages[$];
    for (int s = 0; s < NS; s++) if (mask[s]) stages.push_back(s);

    start_process   = 1'b1;
    data_reset_done = 1'b0;
    num_elements    = CW'(n);
    stage_mask      = mask;
    step();
    chk("idle_waits_reset_done", 32'(current_state), SIdle);
    chk("idle_go_reset_data", 32'(go_reset_data), 1);
    data_reset_done = 1'b1;
    step();
    data_reset_done = 1'b0;
    num_elements    = CW'($urandom);
    stage_mask      = NS'($urandom);

    if (n == 0) begin
      chk("zero_count_done", 32'(current_state), SDone);
      chk("zero_count_no_choose", 32'(go_choose_element), 0);
    end else begin
      for (int e = 0; e < n; e++) begin
        int wait_c;
        wait_c = $urandom_range(0, 1);
        chk("choose_state", 32'(current_state), SChoose);
        chk("choose_go", 32'(go_choose_element), 1);
        chk("choose_index", 32'(elem_index), 32'(e));
        chk("choose_busy", 32'(busy), 1);
        for (int j = 0; j < wait_c; j++) begin
          step();
          chk("choose_waits", 32'(current_state), SChoose);
        end
        element_chosen = 1'b1;
        step();
        element_chosen = 1'b0;
        foreach (stages[k]) begin
          logic [NS-1:0] bit_s;
          int d;
          bit_s = NS'(1) << stages[k];
          d     = $urandom_range(0, 2);
          chk("run_stage_go", 32'(stage_go), 32'(bit_s));
          chk("run_index", 32'(elem_index), 32'(e));
          for (int j = 0; j < d; j++) begin
            stage_done = NS'($urandom) & ~bit_s;
            step();
            chk("run_ignores_other_done", 32'(stage_go), 32'(bit_s));
          end
          stage_done = bit_s | NS'($urandom);
          step();
          stage_done = '0;
        end
      end
      chk("terminal_choose_state", 32'(current_state), SChoose);
      chk("terminal_index", 32'(elem_index), 32'(n));
      element_chosen = 1'b1;
      step();
      element_chosen = 1'b0;
      chk("done_wins_over_chosen", 32'(current_state), SDone);
    end
    chk("end_process", 32'(end_process), 1);
    chk("done_index", 32'(elem_index), 32'(n));
    chk("done_not_busy", 32'(busy), 0);
    chk("done_no_stage_go", 32'(stage_go), 0);
    chk("done_error_low", 32'(error), 0);
    step();
    chk("done_holds_with_start", 32'(current_state), SDone);
    start_process = 1'b0;
    step();
    chk("restart_idle", 32'(current_state), SIdle);
    chk("restart_go_reset_data", 32'(go_reset_data), 1);
    chk("restart_end_cleared", 32'(end_process), 0);
  endtask

  initial begin
    program_reset   = 1'b1;
    start_process   = 1'b0;
    num_elements    = '0;
    stage_mask      = '0;
    data_reset_done = 1'b0;
    element_chosen  = 1'b0;
    stage_done      = '0;
    step();
    step();
    chk("reset_state", 32'(current_state), SIdle);
    chk("reset_go_reset_data", 32'(go_reset_data), 1);
    chk("reset_go_choose", 32'(go_choose_element), 0);
    chk("reset_stage_go", 32'(stage_go), 0);
    chk("reset_index", 32'(elem_index), 0);
    chk("reset_end_process", 32'(end_process), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_error", 32'(error), 0);
    program_reset = 1'b0;
    step();

    run_pass(3, 4'b1111);
    run_pass(2, 4'b1010);
    run_pass(0, 4'b1111);
    run_pass(2, 4'b0000);
    run_pass(1, 4'b1111);
    run_pass(2, 4'b1000);
    run_pass(255, 4'b0000);

    // Reset while stage 2 is active.
    start_process   = 1'b1;
    data_reset_done = 1'b1;
    num_elements    = 8'd2;
    stage_mask      = 4'b1111;
    step();
    data_reset_done = 1'b0;
    element_chosen  = 1'b1;
    step();
    element_chosen  = 1'b0;
    chk("midrun_go0", 32'(stage_go), 32'h1);
    stage_done = 4'b0001;
    step();
    chk("midrun_go1", 32'(stage_go), 32'h2);
    stage_done = 4'b0010;
    step();
    stage_done = '0;
    chk("midrun_go2", 32'(stage_go), 32'h4);
    program_reset = 1'b1;
    step();
    program_reset = 1'b0;
    chk("midrun_reset_state", 32'(current_state), SIdle);
    chk("midrun_reset_stage_go", 32'(stage_go), 0);
    chk("midrun_reset_index", 32'(elem_index), 0);
    chk("midrun_reset_go_reset_data", 32'(go_reset_data), 1);
    start_process = 1'b0;
    step();

    for (int r = 0; r < 8; r++) begin
      run_pass($urandom_range(0, 6), NS'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conversion_sequencer.md
Name: conversion_sequencer

Overview:
Parametrised, restartable successor to the single-pass conversion controller. It walks a latched element count through a configurable chain of NUM_STAGES processing stages using per-stage go/done handshakes. Stages can be skipped at run time through a mask. It sits between the top-level program FSM and the per-element datapath units (FP convert, exponent multiply, resistor invert, memory load, ...).

Parameters:
NUM_STAGES, 4, number of per-element stages; stage 0 runs first, and the last stage is normally the memory load.
CNT_W, 8, width of the element count and the element index.
TMO_W, 16, width of the per-stage watchdog counter (used only with the optional feature).

Ports:
clk  in  1  system clock
program_reset  in  1  synchronous, active-high reset
start_process  in  1  level request to run a conversion pass
num_elements  in  CNT_W  elements per pass; latched on IDLE->CHOOSE
stage_mask  in  NUM_STAGES  1 = stage enabled; latched on IDLE->CHOOSE
data_reset_done  in  1  datapath reset complete
element_chosen  in  1  datapath has fetched element elem_index
stage_done  in  NUM_STAGES  per-stage completion pulse or level
go_reset_data  out  1  high in IDLE
go_choose_element  out  1  high in CHOOSE
stage_go  out  NUM_STAGES  one-hot; active-stage bit high in RUN
elem_index  out  CNT_W  index of the current element
end_process  out  1  high in DONE
busy  out  1  high in CHOOSE or RUN
error  out  1  high in ERROR (tied 0 without the optional feature)
current_state  out  3  state code, for debug and LEDs

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on program_reset, and overrides everything, including mid-stage. After reset: state = IDLE, elem_index = 0, stage pointer = 0, latched count and mask = 0, all go outputs = 0 except go_reset_data = 1, end_process = 0, error = 0.
- Outputs: all outputs are Moore, decoded from registered state only.
- Stage-pointer value: the stage pointer holds the index of the currently active stage.
- Next-enabled-stage function: nxt(p) = the lowest set bit of the latched mask at a position greater than p, or "none" if there is no such bit. first = the lowest set bit overall, or "none".
- IDLE:
  - Exits when data_reset_done & start_process, going to CHOOSE.
  - On that edge it latches num_elements and stage_mask and clears elem_index.
  - If the latched count is 0, it goes directly to DONE.
- CHOOSE:
  - If elem_index == latched count, go to DONE.
  - Else, on element_chosen:
    - if first exists, go to RUN with pointer = first;
    - if first is none, increment elem_index and stay in CHOOSE.
  - Without element_chosen, wait indefinitely.
- RUN:
  - stage_go[pointer] = 1 for the whole stay; only stage_done[pointer] is sampled, and other bits are ignored.
  - On done with nxt(pointer) existing: pointer <= nxt and stay in RUN. The next stage's go rises 1 cycle after done is sampled.
  - On done with nxt(pointer) = none: elem_index + 1 and go to CHOOSE.
- DONE:
  - end_process = 1 and all counters hold.
  - When start_process deasserts, return to IDLE; the block is restartable without reset.
  - If start_process stays high, remain in DONE; there is no auto-rerun.
- ERROR: defined under the optional feature. It is left only by program_reset.
- Latency: minimum per element with k enabled stages = 1 (CHOOSE) + k cycles when every done is returned on the first go cycle.
- Input changes mid-pass: changes to num_elements or stage_mask are ignored until the next IDLE exit.
- elem_index width: it never wraps, because its terminal value is at most 2^CNT_W - 1. A count of 2^CNT_W - 1 runs elements 0 to 2^CNT_W - 2.
- Simultaneous events: in CHOOSE, element_chosen arriving with elem_index == count is ignored; DONE wins.

Optional Feature:
CONV_SEQ_STAGE_TIMEOUT_EN
- With the macro: a TMO_W-bit watchdog clears on every RUN entry and every stage advance, and increments each RUN cycle without done. On reaching all-ones, the block goes to ERROR: error = 1, all go outputs = 0, and elem_index and the pointer freeze for debug.
- Without the macro: no counter is built, ERROR is unreachable, and error is tied 0.

Decomposition:
- Package conv_seq_pkg holds:
  - the state codes: IDLE = 0, CHOOSE = 1, RUN = 2, DONE = 3, ERROR = 4;
  - the 3-bit state width constant.
- Sub-module next_stage_finder (parametrised by NUM_STAGES): a combinational masked priority encoder. Inputs are the mask and the pointer; outputs are the next index and a valid flag. With pointer = -1 (a separate "from_start" input) it produces first.
- The FSM, counters and watchdog stay in conversion_sequencer.

Test Plan:
- Basic pass: num_elements = 3, mask = 4'b1111, done returned 2 cycles after each go -> stage_go sequence 1,2,4,8 repeated 3 times; elem_index goes 0->1->2->3; end_process rises.
- Mask skip: mask = 4'b1010 with 2 elements -> only stage_go = 2 then 8 per element; stage_done[0] and stage_done[2] pulses are ignored.
- Edge counts:
  - num_elements = 0 -> DONE the cycle after start, with no go_choose_element.
  - mask = 0 with num_elements = 2 -> two element_chosen pulses, then DONE, with no stage_go.
- Restart: after DONE, drop start_process for 1 cycle and raise it with num_elements = 1 -> go_reset_data, then a new pass; elem_index restarts at 0.
- Reset mid-RUN: assert program_reset while stage_go = 4 -> next cycle state = IDLE, stage_go = 0, elem_index = 0.
- Timeout (feature on, TMO_W = 4): hold stage_done = 0 in RUN -> error = 1 after 15 cycles; state stays ERROR until reset.
